// File: rtl/cam_cmd_ctrl.sv
// UART command controller for the OV7670 FIFO block: decodes single-byte
// commands, sequences captures and streams a fixed-length frame over UART,
// optionally followed by a 16-bit additive checksum trailer.
module cam_cmd_ctrl #(
    parameter int unsigned FRAME_BYTES = 153600,
    parameter int unsigned CNT_W       = 18,
    parameter int unsigned TX_GAP      = 3,
    parameter int unsigned RD_TIMEOUT  = 255,
    parameter int unsigned TO_W        = 8
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_rx_done,
    input  logic [7:0]       i_rx_data,
    input  logic             i_tx_busy,
    output logic [7:0]       o_tx_data,
    output logic             o_tx_en,
    input  logic             i_fifo_busy,
    output logic             o_capture_start,
    output logic             o_read_start,
    input  logic             i_fifo_rrst_done,
    output logic             o_fifo_rd_byte_str,
    input  logic             i_data_ready,
    input  logic [7:0]       i_data_from_fifo,
    output logic             o_busy,
    output logic             o_frame_valid,
    output logic             o_err,
    output logic [CNT_W-1:0] o_byte_count
);

    typedef enum logic [3:0] {
        StIdle, StDecode, StCapReq, StCapHi, StCapLo, StRdReq, StRdRrst,
        StReq, StWaitData, StTx, StGap, StCsumHi, StCsumLo
    } state_e;

    state_e            state_q, state_d, ret_q, ret_d;
    logic [7:0]        cmd_q, cmd_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic [7:0]        gap_q, gap_d;
    logic [TO_W-1:0]   to_q, to_d;
    logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
    logic [15:0]       csum_q, csum_d;
    logic              csum_mode_q, csum_mode_d;
    logic              frame_valid_q, frame_valid_d;
    logic              err_q, err_d;
    logic              cap_start_q, cap_start_d;
    logic              rd_start_q, rd_start_d;

    logic              frame_done;
    logic              send_en;
    logic [7:0]        send_byte;
    state_e            send_ret;

    assign frame_done = (byte_cnt_q == CNT_W'(FRAME_BYTES));

    // Next-state logic; any state that transmits routes through TX/GAP via send_*.
    always_comb begin
        state_d       = state_q;
        ret_d         = ret_q;
        cmd_d         = cmd_q;
        tx_data_d     = tx_data_q;
        gap_d         = gap_q;
        to_d          = to_q;
        byte_cnt_d    = byte_cnt_q;
        csum_d        = csum_q;
        csum_mode_d   = csum_mode_q;
        frame_valid_d = frame_valid_q;
        err_d         = err_q;
        cap_start_d   = 1'b0;
        rd_start_d    = 1'b0;
        send_en       = 1'b0;
        send_byte     = 8'h00;
        send_ret      = StIdle;

        case (state_q)
            StIdle: begin
                if (i_rx_done) begin
                    cmd_d   = i_rx_data;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                case (cmd_q)
                    8'h31: state_d = StCapReq;
                    8'h32, 8'h33: begin
                        if (frame_valid_q) begin
                            csum_mode_d = (cmd_q == 8'h33);
                            byte_cnt_d  = '0;
                            csum_d      = '0;
                            state_d     = StRdReq;
                        end else begin
                            send_en   = 1'b1;
                            send_byte = 8'h4E;
                        end
                    end
                    8'h34: begin
                        send_en   = 1'b1;
                        send_byte = {4'h5, 1'b0, err_q, frame_valid_q, i_fifo_busy};
                    end
                    default: begin
                        send_en   = 1'b1;
                        send_byte = 8'h3F;
                    end
                endcase
            end
            StCapReq: begin
                if (!i_fifo_busy) begin
                    cap_start_d = 1'b1;
                    state_d     = StCapHi;
                end
            end
            StCapHi: begin
                if (i_fifo_busy) state_d = StCapLo;
            end
            StCapLo: begin
                if (!i_fifo_busy) begin
                    frame_valid_d = 1'b1;
                    err_d         = 1'b0;
                    send_en       = 1'b1;
                    send_byte     = 8'h31;
                end
            end
            StRdReq: begin
                if (!i_fifo_busy) begin
                    rd_start_d = 1'b1;
                    state_d    = StRdRrst;
                end
            end
            StRdRrst: begin
                if (i_fifo_rrst_done) state_d = StReq;
            end
            StReq: begin
                if (frame_done) begin
                    state_d = csum_mode_q ? StCsumHi : StIdle;
                end else begin
                    to_d    = '0;
                    state_d = StWaitData;
                end
            end
            StWaitData: begin
                // Data arriving on the timeout cycle is still accepted.
                if (i_data_ready) begin
                    csum_d     = csum_q + {8'h00, i_data_from_fifo};
                    byte_cnt_d = byte_cnt_q + 1'b1;
                    send_en    = 1'b1;
                    send_byte  = i_data_from_fifo;
                    send_ret   = StReq;
                end else if (to_q == TO_W'(RD_TIMEOUT)) begin
                    err_d     = 1'b1;
                    send_en   = 1'b1;
                    send_byte = 8'h45;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            StTx: begin
                gap_d   = '0;
                state_d = StGap;
            end
            StGap: begin
                if (i_tx_busy) begin
                    gap_d = '0;
                end else if (gap_q == 8'(TX_GAP - 1)) begin
                    state_d = ret_q;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            StCsumHi: begin
                send_en   = 1'b1;
                send_byte = csum_q[15:8];
                send_ret  = StCsumLo;
            end
            StCsumLo: begin
                send_en   = 1'b1;
                send_byte = csum_q[7:0];
            end
            default: state_d = StIdle;
        endcase

        if (send_en) begin
            tx_data_d = send_byte;
            ret_d     = send_ret;
            state_d   = StTx;
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q       <= StIdle;
            ret_q         <= StIdle;
            cmd_q         <= '0;
            tx_data_q     <= '0;
            gap_q         <= '0;
            to_q          <= '0;
            byte_cnt_q    <= '0;
            csum_q        <= '0;
            csum_mode_q   <= 1'b0;
            frame_valid_q <= 1'b0;
            err_q         <= 1'b0;
            cap_start_q   <= 1'b0;
            rd_start_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            ret_q         <= ret_d;
            cmd_q         <= cmd_d;
            tx_data_q     <= tx_data_d;
            gap_q         <= gap_d;
            to_q          <= to_d;
            byte_cnt_q    <= byte_cnt_d;
            csum_q        <= csum_d;
            csum_mode_q   <= csum_mode_d;
            frame_valid_q <= frame_valid_d;
            err_q         <= err_d;
            cap_start_q   <= cap_start_d;
            rd_start_q    <= rd_start_d;
        end
    end

    // Outputs are decoded from registered state only.
    always_comb begin
        o_tx_data          = tx_data_q;
        o_tx_en            = (state_q == StTx);
        o_capture_start    = cap_start_q;
        o_read_start       = rd_start_q;
        o_fifo_rd_byte_str = (state_q == StReq) && !frame_done;
        o_busy             = (state_q != StIdle);
        o_frame_valid      = frame_valid_q;
        o_err              = err_q;
        o_byte_count       = byte_cnt_q;
    end

endmodule

// File: tb/tb_cam_cmd_ctrl.sv
// Directed bench for cam_cmd_ctrl with small UART and FIFO behavioural models.
module tb_cam_cmd_ctrl;

    localparam int unsigned FRAME_BYTES = 4;
    localparam int unsigned CNT_W       = 18;
    localparam int unsigned TX_GAP      = 3;
    localparam int unsigned RD_TIMEOUT  = 8;
    localparam int unsigned TO_W        = 8;

    logic             clk = 1'b0;
    logic             i_rstn = 1'b0;
    logic             i_rx_done = 1'b0;
    logic [7:0]       i_rx_data = 8'h00;
    logic             i_tx_busy = 1'b0;
    logic             i_fifo_busy = 1'b0;
    logic             i_fifo_rrst_done = 1'b0;
    logic             i_data_ready = 1'b0;
    logic [7:0]       i_data_from_fifo = 8'h00;
    logic [7:0]       o_tx_data;
    logic             o_tx_en, o_capture_start, o_read_start, o_fifo_rd_byte_str;
    logic             o_busy, o_frame_valid, o_err;
    logic [CNT_W-1:0] o_byte_count;

    cam_cmd_ctrl #(
        .FRAME_BYTES(FRAME_BYTES), .CNT_W(CNT_W), .TX_GAP(TX_GAP),
        .RD_TIMEOUT(RD_TIMEOUT), .TO_W(TO_W)
    ) dut (
        .i_clk(clk), .i_rstn(i_rstn), .i_rx_done(i_rx_done), .i_rx_data(i_rx_data),
        .i_tx_busy(i_tx_busy), .o_tx_data(o_tx_data), .o_tx_en(o_tx_en),
        .i_fifo_busy(i_fifo_busy), .o_capture_start(o_capture_start),
        .o_read_start(o_read_start), .i_fifo_rrst_done(i_fifo_rrst_done),
        .o_fifo_rd_byte_str(o_fifo_rd_byte_str), .i_data_ready(i_data_ready),
        .i_data_from_fifo(i_data_from_fifo), .o_busy(o_busy),
        .o_frame_valid(o_frame_valid), .o_err(o_err), .o_byte_count(o_byte_count)
    );

    always #5 clk = ~clk;

    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] txq[$];
    logic [7:0] expq[$];
    logic [7:0] fifo_mem[8];
    int         silent_after = 99;
    int         cap_pulses = 0;
    int         rd_pulses = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // UART tx model: busy for 4 cycles after each request.
    int tx_cnt = 0;
    always @(negedge clk) begin
        if (tx_cnt > 0) tx_cnt--;
        if (o_tx_en === 1'b1) tx_cnt = 4;
        i_tx_busy = (tx_cnt > 0);
    end

    // FIFO model: 10-cycle capture, read-pointer reset and byte reads 2 cycles later.
    int cap_cnt = 0;
    int rr_cnt = 0;
    int dr_cnt = 0;
    int rd_idx = 0;
    always @(negedge clk) begin
        i_fifo_rrst_done = 1'b0;
        i_data_ready     = 1'b0;
        if (cap_cnt > 0) cap_cnt--;
        if (o_capture_start === 1'b1) cap_cnt = 10;
        i_fifo_busy = (cap_cnt > 0);
        if (rr_cnt > 0) begin
            rr_cnt--;
            if (rr_cnt == 0) i_fifo_rrst_done = 1'b1;
        end
        if (o_read_start === 1'b1) begin
            rr_cnt = 2;
            rd_idx = 0;
        end
        if (dr_cnt > 0) begin
            dr_cnt--;
            if (dr_cnt == 0) begin
                i_data_ready     = 1'b1;
                i_data_from_fifo = fifo_mem[rd_idx];
                rd_idx++;
            end
        end
        if (o_fifo_rd_byte_str === 1'b1 && rd_idx < silent_after) dr_cnt = 2;
    end

    // Output monitor: collects tx bytes, counts pulses, checks exclusivity and spacing.
    int since_tx = 0;
    bit have_prev = 1'b0;
    always @(negedge clk) begin
        int n;
        since_tx++;
        n = int'(o_tx_en === 1'b1) + int'(o_capture_start === 1'b1) +
            int'(o_read_start === 1'b1) + int'(o_fifo_rd_byte_str === 1'b1);
        if (n > 0) chk("pulse_onehot", n, 1);
        if (o_capture_start === 1'b1) cap_pulses++;
        if (o_read_start === 1'b1) rd_pulses++;
        if (o_tx_en === 1'b1) begin
            txq.push_back(o_tx_data);
            if (have_prev) chk("tx_spacing_ok", since_tx >= TX_GAP + 1, 1);
            have_prev = 1'b1;
            since_tx  = 0;
        end
    end

    task automatic send_cmd(input logic [7:0] b);
        @(negedge clk);
        i_rx_data = b;
        i_rx_done = 1'b1;
        @(negedge clk);
        i_rx_done = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        @(negedge clk);
        while (o_busy !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_idle"}, o_busy, 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic chk_tx(input string tag);
        chk({tag, "_ntx"}, txq.size(), expq.size());
        for (int i = 0; i < expq.size(); i++) begin
            if (i < txq.size()) chk($sformatf("%s_b%0d", tag, i), txq[i], expq[i]);
        end
        txq.delete();
    endtask

    function automatic logic [63:0] all_out();
        return {o_tx_data, o_tx_en, o_capture_start, o_read_start, o_fifo_rd_byte_str,
                o_busy, o_frame_valid, o_err, o_byte_count};
    endfunction

    initial begin
        // Reset held with rx inputs toggling.
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_outputs", all_out(), 0);
            i_rx_done = ~i_rx_done;
            i_rx_data = 8'h31 + 8'(i);
        end
        i_rx_done = 1'b0;
        i_rstn    = 1'b1;
        @(negedge clk);
        chk("post_rst_outputs", all_out(), 0);
        txq.delete();

        // Status query after reset, with 2-cycle ack latency.
        send_cmd(8'h34);
        @(negedge clk);
        chk("status_latency", o_tx_en, 1);
        wait_idle("status0", 50);
        expq = '{8'h50};
        chk_tx("status0");

        // Download before any capture.
        send_cmd(8'h32);
        wait_idle("nocap", 50);
        expq = '{8'h4E};
        chk_tx("nocap");
        chk("nocap_rd_pulses", rd_pulses, 0);

        // Capture.
        send_cmd(8'h31);
        wait_idle("cap", 200);
        expq = '{8'h31};
        chk_tx("cap");
        chk("cap_pulses", cap_pulses, 1);
        chk("cap_frame_valid", o_frame_valid, 1);
        send_cmd(8'h34);
        wait_idle("status1", 50);
        expq = '{8'h52};
        chk_tx("status1");

        // Checksum download; a command arriving mid-download is dropped.
        fifo_mem[0] = 8'hFF; fifo_mem[1] = 8'h01; fifo_mem[2] = 8'h10; fifo_mem[3] = 8'h20;
        silent_after = 99;
        send_cmd(8'h33);
        repeat (15) @(negedge clk);
        send_cmd(8'h34);
        wait_idle("csum", 500);
        expq = '{8'hFF, 8'h01, 8'h10, 8'h20, 8'h01, 8'h30};
        chk_tx("csum");
        chk("csum_byte_count", o_byte_count, 4);
        chk("csum_rd_pulses", rd_pulses, 1);

        // FIFO goes silent after two bytes.
        fifo_mem[0] = 8'hAA; fifo_mem[1] = 8'hBB;
        silent_after = 2;
        send_cmd(8'h32);
        wait_idle("tmo", 500);
        expq = '{8'hAA, 8'hBB, 8'h45};
        chk_tx("tmo");
        chk("tmo_err", o_err, 1);
        chk("tmo_byte_count", o_byte_count, 2);
        send_cmd(8'h34);
        wait_idle("status2", 50);
        expq = '{8'h56};
        chk_tx("status2");
        send_cmd(8'h31);
        wait_idle("cap2", 200);
        expq = '{8'h31};
        chk_tx("cap2");
        chk("cap2_err_cleared", o_err, 0);

        // Reset in the middle of a download.
        fifo_mem[0] = 8'h11; fifo_mem[1] = 8'h22; fifo_mem[2] = 8'h33; fifo_mem[3] = 8'h44;
        silent_after = 99;
        send_cmd(8'h32);
        begin
            int n = 0;
            while (txq.size() < 2 && n < 300) begin
                @(negedge clk);
                n++;
            end
        end
        chk("mid_two_bytes", txq.size(), 2);
        i_rstn = 1'b0;
        @(negedge clk);
        chk("mid_rst_outputs", all_out(), 0);
        chk("mid_rst_frame_valid", o_frame_valid, 0);
        i_rstn = 1'b1;
        repeat (10) @(negedge clk);
        expq = '{8'h11, 8'h22};
        chk_tx("mid");
        send_cmd(8'h32);
        wait_idle("after_rst", 50);
        expq = '{8'h4E};
        chk_tx("after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
